// File: rtl/cell_lane_control.sv
// Per-lane divergence control for a SIMD cell array sharing one instruction stream.
// Optional park timeout watchdog enabled by defining CELL_LANE_PARK_TIMEOUT_EN.

`ifndef UNL
`define UNL 4'hB
`endif
`ifndef JUMP
`define JUMP 4'hC
`endif
`ifndef REG_MY
`define REG_MY 4'hF
`endif

module cell_lane_control #(
  parameter int REGISTER_LENGTH = 8,
  parameter int LANES           = 4,
  parameter int PC_WIDTH        = 12,
  parameter int SP_WIDTH        = 5,
  parameter int TIMEOUT_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LANES*REGISTER_LENGTH-1:0]   target_value,
  input  logic [15:0]                        instruction,
  input  logic [PC_WIDTH-1:0]                next_program_counter,
  input  logic [SP_WIDTH-1:0]                next_stack_pointer,
  input  logic                               execution_enable,
  output logic [LANES-1:0]                   enable,
  output logic [LANES-1:0]                   state_change_enable,
  output logic [LANES-1:0]                   diverge,
  output logic                               all_diverged,
  output logic [$clog2(LANES+1)-1:0]         active_count,
  output logic [LANES-1:0]                   timeout
);

  localparam int COUNT_WIDTH = $clog2(LANES + 1);

  logic [3:0]          opcode;
  logic [3:0]          target;
  logic [7:0]          immediate;
  logic [PC_WIDTH-1:0] immediate_pc;

  assign opcode       = instruction[15:12];
  assign target       = instruction[11:8];
  assign immediate    = instruction[7:0];
  assign immediate_pc = PC_WIDTH'(immediate);

  logic [PC_WIDTH-1:0] local_pc [LANES];
  logic [SP_WIDTH-1:0] local_sp [LANES];
  logic [LANES-1:0]    parked;
  logic [LANES-1:0]    rejoin;

  always_comb begin
    diverge             = '0;
    enable              = '0;
    state_change_enable = '0;
    rejoin              = '0;
    active_count        = '0;
    for (int i = 0; i < LANES; i++) begin
      diverge[i] = ((opcode == `UNL) &&
                    (target_value[i*REGISTER_LENGTH +: REGISTER_LENGTH] == '0)) || parked[i];
      enable[i]  = execution_enable && !diverge[i] && (opcode != `JUMP);
      state_change_enable[i] = enable[i] && (target == `REG_MY);
      rejoin[i]  = parked[i] && (next_program_counter == local_pc[i]) &&
                   (next_stack_pointer == local_sp[i]);
      if (!diverge[i])
        active_count = active_count + COUNT_WIDTH'(1);
    end
    all_diverged = &diverge;
  end

  // A diverging lane remembers where it must rejoin; it parks only if the
  // stream is not already heading to that same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      parked <= '0;
      for (int i = 0; i < LANES; i++) begin
        local_pc[i] <= '0;
        local_sp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (parked[i]) begin
          if (rejoin[i])
            parked[i] <= 1'b0;
        end else if (diverge[i]) begin
          local_pc[i] <= immediate_pc;
          local_sp[i] <= next_stack_pointer;
          parked[i]   <= (next_program_counter != immediate_pc);
        end else begin
          local_pc[i] <= next_program_counter;
          local_sp[i] <= next_stack_pointer;
        end
      end
    end
  end

`ifdef CELL_LANE_PARK_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = ~TIMEOUT_WIDTH'(1);

  logic [TIMEOUT_WIDTH-1:0] park_timer [LANES];
  logic [LANES-1:0]         timeout_q;

  // Timer saturates at all-ones; the flag is raised on the edge it gets there
  // and is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= '0;
      for (int i = 0; i < LANES; i++)
        park_timer[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (rejoin[i]) begin
          park_timer[i] <= '0;
        end else if (parked[i] && (park_timer[i] != '1)) begin
          park_timer[i] <= park_timer[i] + 1'b1;
          if (park_timer[i] == TIMER_LAST)
            timeout_q[i] <= 1'b1;
        end
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

endmodule

// File: tb/tb_cell_lane_control.sv
// Randomized self-checking bench for cell_lane_control with a per-lane behavioural model.
// Honours CELL_LANE_PARK_TIMEOUT_EN for the timeout expectations.

`ifndef UNL
`define UNL 4'hB
`endif
`ifndef JUMP
`define JUMP 4'hC
`endif
`ifndef REG_MY
`define REG_MY 4'hF
`endif

module tb_cell_lane_control;

  localparam int RL  = 8;
  localparam int NL  = 4;
  localparam int PCW = 12;
  localparam int SPW = 5;
  localparam int TW  = 4;
  localparam int CW  = $clog2(NL + 1);
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam int TIMER_MAX = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NL*RL-1:0]  target_value = '0;
  logic [15:0]       instruction = '0;
  logic [PCW-1:0]    next_program_counter = '0;
  logic [SPW-1:0]    next_stack_pointer = '0;
  logic              execution_enable = 1'b0;
  logic [NL-1:0]     enable;
  logic [NL-1:0]     state_change_enable;
  logic [NL-1:0]     diverge;
  logic              all_diverged;
  logic [CW-1:0]     active_count;
  logic [NL-1:0]     timeout;

  cell_lane_control #(
    .REGISTER_LENGTH(RL), .LANES(NL), .PC_WIDTH(PCW), .SP_WIDTH(SPW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .target_value(target_value), .instruction(instruction),
    .next_program_counter(next_program_counter), .next_stack_pointer(next_stack_pointer),
    .execution_enable(execution_enable), .enable(enable),
    .state_change_enable(state_change_enable), .diverge(diverge),
    .all_diverged(all_diverged), .active_count(active_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: each lane is a rejoin address, a stack depth and a parked flag.
  int m_pc [NL];
  int m_sp [NL];
  bit m_parked [NL];
  int m_timer [NL];
  bit m_timeout [NL];
  bit model_valid = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lane_value(input int i);
    return int'(target_value[i*RL +: RL]);
  endfunction

  // Expected outputs are derived from the lane rules each cycle before the edge.
  task automatic checkOutput();
    logic [NL-1:0] e_div, e_en, e_sce, e_to;
    int e_active;
    bit is_unl, is_jump;
    if (!model_valid) return;
    is_unl   = (instruction[15:12] == `UNL);
    is_jump  = (instruction[15:12] == `JUMP);
    e_active = 0;
    for (int i = 0; i < NL; i++) begin
      e_div[i] = (is_unl && lane_value(i) == 0) || m_parked[i];
      e_en[i]  = execution_enable && !e_div[i] && !is_jump;
      e_sce[i] = e_en[i] && (instruction[11:8] == `REG_MY);
      e_to[i]  = m_timeout[i];
      if (!e_div[i]) e_active++;
    end
    check("diverge", 32'(diverge), 32'(e_div));
    check("enable", 32'(enable), 32'(e_en));
    check("state_change_enable", 32'(state_change_enable), 32'(e_sce));
    check("all_diverged", 32'(all_diverged), 32'(e_div == '1));
    check("active_count", 32'(active_count), 32'(e_active));
    check("timeout", 32'(timeout), 32'(e_to));
  endtask

  task automatic updateModel();
    int npc, nsp, imm;
    bit is_unl;
    npc = int'(next_program_counter);
    nsp = int'(next_stack_pointer);
    imm = int'(instruction[7:0]);
    is_unl = (instruction[15:12] == `UNL);
    for (int i = 0; i < NL; i++) begin
      if (rst) begin
        m_pc[i] = 0; m_sp[i] = 0; m_parked[i] = 0; m_timer[i] = 0; m_timeout[i] = 0;
      end else if (m_parked[i]) begin
        if (npc == m_pc[i] && nsp == m_sp[i]) begin
          m_parked[i] = 0;
          m_timer[i]  = 0;
        end else begin
`ifdef CELL_LANE_PARK_TIMEOUT_EN
          if (m_timer[i] < TIMER_MAX) m_timer[i]++;
          if (m_timer[i] == TIMER_MAX) m_timeout[i] = 1;
`endif
        end
      end else if (is_unl && lane_value(i) == 0) begin
        m_pc[i] = imm;
        m_sp[i] = nsp;
        m_parked[i] = (npc != imm);
      end else begin
        m_pc[i] = npc;
        m_sp[i] = nsp;
      end
    end
    if (rst) model_valid = 1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] tgt, input logic [7:0] imm,
                               input logic [NL*RL-1:0] tv, input int npc, input int nsp,
                               input logic ex, input logic r);
    @(negedge clk);
    instruction          = {op, tgt, imm};
    target_value         = tv;
    next_program_counter = PCW'(npc);
    next_stack_pointer   = SPW'(nsp);
    execution_enable     = ex;
    rst                  = r;
    #1;
    checkOutput();
    updateModel();
  endtask

  localparam logic [NL*RL-1:0] TV_ZERO  = '0;
  localparam logic [NL*RL-1:0] TV_SPLIT = {8'd5, 8'd5, 8'd5, 8'd0};

  initial begin
    logic [3:0] op;
    logic [NL*RL-1:0] tv;
    int npc, pick;

    // Reset, then ADD with execution enabled: every lane active.
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_ZERO, 0, 0, 1'b1, 1'b1);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_ZERO, 0, 0, 1'b1, 1'b0);
    check("lit_reset_diverge", 32'(diverge), 32'h0);
    check("lit_reset_active", 32'(active_count), 32'd4);
    check("lit_reset_enable", 32'(enable), 32'hF);
    check("lit_reset_timeout", 32'(timeout), 32'h0);

    // Uniform branch: all lanes take it, nobody parks.
    applyStimulus(`UNL, 4'h0, 8'h20, TV_ZERO, 'h020, 1, 1'b1, 1'b0);
    check("lit_uniform_diverge", 32'(diverge), 32'hF);
    check("lit_uniform_all", 32'(all_diverged), 32'd1);
    applyStimulus(OP_ADD, `REG_MY, 8'h00, TV_ZERO, 'h021, 1, 1'b1, 1'b0);
    check("lit_uniform_next_enable", 32'(enable), 32'hF);
    check("lit_uniform_next_sce", 32'(state_change_enable), 32'hF);

    // Split: lane 0 parks at 0x20/SP 2, then rejoins.
    applyStimulus(`UNL, 4'h0, 8'h20, TV_SPLIT, 'h011, 2, 1'b1, 1'b0);
    check("lit_split_diverge", 32'(diverge), 32'h1);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h020, 2, 1'b1, 1'b0);
    check("lit_split_parked", 32'(diverge), 32'h1);
    check("lit_split_active", 32'(active_count), 32'd3);
    applyStimulus(`JUMP, 4'h0, 8'h00, TV_SPLIT, 'h030, 2, 1'b1, 1'b0);
    check("lit_split_released", 32'(diverge), 32'h0);
    check("lit_jump_enable", 32'(enable), 32'h0);

    // SP mismatch keeps the lane parked; reset mid-park releases it.
    applyStimulus(`UNL, 4'h0, 8'h20, TV_SPLIT, 'h011, 3, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h020, 4, 1'b1, 1'b0);
    check("lit_spmis_active", 32'(active_count), 32'd3);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h020, 4, 1'b1, 1'b1);
    check("lit_spmis_still_parked", 32'(diverge), 32'h1);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h020, 4, 1'b1, 1'b0);
    check("lit_midpark_reset", 32'(diverge), 32'h0);

    // Long park: the timeout flag appears after 15 parked cycles and is sticky.
    applyStimulus(`UNL, 4'h0, 8'h20, TV_SPLIT, 'h011, 0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++)
      applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h100, 0, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h020, 0, 1'b1, 1'b0);
`ifdef CELL_LANE_PARK_TIMEOUT_EN
    check("lit_timeout_set", 32'(timeout), 32'h1);
`else
    check("lit_timeout_tied", 32'(timeout), 32'h0);
`endif
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h021, 0, 1'b1, 1'b0);
    check("lit_timeout_rejoined", 32'(diverge), 32'h0);
`ifdef CELL_LANE_PARK_TIMEOUT_EN
    check("lit_timeout_sticky", 32'(timeout), 32'h1);
`endif
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h021, 0, 1'b1, 1'b1);
    applyStimulus(OP_ADD, 4'h0, 8'h00, TV_SPLIT, 'h021, 0, 1'b1, 1'b0);
    check("lit_timeout_cleared", 32'(timeout), 32'h0);

    // Random traffic: narrow PC/SP ranges and model-guided PCs make rejoins frequent.
    for (int n = 0; n < 3000; n++) begin
      pick = int'($urandom_range(0, 9));
      op = (pick < 4) ? `UNL : (pick < 5) ? `JUMP : (pick < 8) ? OP_ADD : 4'($urandom);
      for (int i = 0; i < NL; i++)
        tv[i*RL +: RL] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      pick = int'($urandom_range(0, 3));
      npc = (pick == 0) ? m_pc[$urandom_range(0, NL-1)] : int'($urandom_range(0, 'h40));
      applyStimulus(op, 4'($urandom), 8'($urandom_range(0, 'h40)), tv, npc,
                    int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
